// File: rtl/controlador_pisca_leds.sv
// Blink sequencer for the game's hit LEDs: latches a mask, then runs N_PISCADAS lit/dark phases and pulses fim.
// Latency: leds follow the mask one cycle after an accepted iniciar; no backpressure, iniciar is ignored while ocupado.
module controlador_pisca_leds #(
    parameter int N_LEDS     = 4,
    parameter int T_ON       = 500,
    parameter int T_OFF      = 500,
    parameter int N_PISCADAS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [N_LEDS-1:0] mascara,
    output logic [N_LEDS-1:0] leds,
    output logic              ocupado,
    output logic              fim,
    output logic [3:0]        db_piscadas,
    output logic [1:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] TON_ULT  = CW'(T_ON - 1);
    localparam logic [CW-1:0] TOFF_ULT = CW'(T_OFF - 1);
    localparam logic [3:0]    NP       = 4'(N_PISCADAS);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESO   = 2'd1,
        APAGADO = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t           estado_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        piscadas_q;
    logic [N_LEDS-1:0] mask_q;
    logic [N_LEDS-1:0] leds_q;
    logic              ocupado_q;
    logic              fim_q;

    logic [3:0]        piscadas_d;

    assign piscadas_d = piscadas_q + 4'd1;

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            piscadas_q <= '0;
            mask_q     <= '0;
            leds_q     <= '0;
            ocupado_q  <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar && !cancelar) begin
                        estado_q   <= ACESO;
                        mask_q     <= mascara;
                        leds_q     <= mascara;
                        cnt_q      <= '0;
                        piscadas_q <= '0;
                        ocupado_q  <= 1'b1;
                    end
                end
                ACESO: begin
                    if (cancelar) begin
                        estado_q  <= OCIOSO;
                        cnt_q     <= '0;
                        leds_q    <= '0;
                        ocupado_q <= 1'b0;
                    end else if (cnt_q == TON_ULT) begin
                        cnt_q      <= '0;
                        piscadas_q <= piscadas_d;
                        leds_q     <= '0;
                        if (piscadas_d == NP) begin
                            estado_q <= FIM;
                            fim_q    <= 1'b1;
                        end else begin
                            estado_q <= APAGADO;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                APAGADO: begin
                    if (cancelar) begin
                        estado_q  <= OCIOSO;
                        cnt_q     <= '0;
                        leds_q    <= '0;
                        ocupado_q <= 1'b0;
                    end else if (cnt_q == TOFF_ULT) begin
                        cnt_q    <= '0;
                        estado_q <= ACESO;
                        leds_q   <= mask_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    estado_q  <= OCIOSO;
                    cnt_q     <= '0;
                    leds_q    <= '0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign leds        = leds_q;
    assign ocupado     = ocupado_q;
    assign fim         = fim_q;
    assign db_piscadas = piscadas_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_controlador_pisca_leds.sv
// Directed bench for controlador_pisca_leds with T_ON=3, T_OFF=2, N_PISCADAS=2.
module tb_controlador_pisca_leds;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       cancelar;
    logic [3:0] mascara;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_piscadas;
    logic [1:0] db_estado;

    int checks = 0;
    int errors = 0;

    // Expected state after edge e, e = 0 being the edge that accepts iniciar.
    logic [1:0] est_ref [0:11] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1,
                                   2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0};

    controlador_pisca_leds #(
        .N_LEDS(4), .T_ON(3), .T_OFF(2), .N_PISCADAS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .cancelar(cancelar),
        .mascara(mascara),
        .leds(leds),
        .ocupado(ocupado),
        .fim(fim),
        .db_piscadas(db_piscadas),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks every output for 12 cycles after a start; cancel_at/restart_at < 0 disables them.
    task automatic sequencia(input logic [3:0] m, input int cancel_at, input int restart_at,
                             input logic [3:0] exp_pisc, input string nm);
        logic [1:0] est;
        @(negedge clock);
        iniciar  = 1'b1;
        cancelar = 1'b0;
        mascara  = m;
        for (int e = 0; e < 12; e++) begin
            @(posedge clock);
            #1;
            est = (cancel_at >= 0 && e >= cancel_at) ? 2'd0 : est_ref[e];
            confere({nm, "_estado"},  32'(db_estado), 32'(est));
            confere({nm, "_leds"},    32'(leds),      (est == 2'd1) ? 32'(m) : 32'd0);
            confere({nm, "_fim"},     32'(fim),       (est == 2'd3) ? 32'd1 : 32'd0);
            confere({nm, "_ocupado"}, 32'(ocupado),   (est != 2'd0) ? 32'd1 : 32'd0);
            @(negedge clock);
            iniciar  = (e + 1 == restart_at);
            cancelar = (e + 1 == cancel_at);
            mascara  = (restart_at >= 0) ? 4'b1111 : ~m;
        end
        confere({nm, "_piscadas"}, 32'(db_piscadas), 32'(exp_pisc));
        iniciar  = 1'b0;
        cancelar = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        iniciar  = 1'b0;
        cancelar = 1'b0;
        mascara  = 4'b0000;
        #12;
        confere("rst_leds",     32'(leds),        32'd0);
        confere("rst_ocupado",  32'(ocupado),     32'd0);
        confere("rst_fim",      32'(fim),         32'd0);
        confere("rst_piscadas", 32'(db_piscadas), 32'd0);
        confere("rst_estado",   32'(db_estado),   32'd0);
        @(negedge clock);
        reset = 1'b0;

        sequencia(4'b0101, -1, -1, 4'd2, "normal");
        sequencia(4'b0101,  5, -1, 4'd1, "cancela");
        sequencia(4'b0101, -1,  2, 4'd2, "reinicia");

        // iniciar together with cancelar while idle must not start
        @(negedge clock);
        iniciar  = 1'b1;
        cancelar = 1'b1;
        mascara  = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            confere("simult_ocupado", 32'(ocupado),   32'd0);
            confere("simult_estado",  32'(db_estado), 32'd0);
            confere("simult_leds",    32'(leds),      32'd0);
        end
        @(negedge clock);
        iniciar  = 1'b0;
        cancelar = 1'b0;

        sequencia(4'b0000, -1, -1, 4'd2, "mascara0");

        // asynchronous reset in the middle of the second lit phase
        @(negedge clock);
        iniciar = 1'b1;
        mascara = 4'b0110;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        confere("pre_rst_leds", 32'(leds), 32'b0110);
        #2;
        reset = 1'b1;
        #1;
        confere("mid_rst_leds",     32'(leds),        32'd0);
        confere("mid_rst_ocupado",  32'(ocupado),     32'd0);
        confere("mid_rst_fim",      32'(fim),         32'd0);
        confere("mid_rst_estado",   32'(db_estado),   32'd0);
        confere("mid_rst_piscadas", 32'(db_piscadas), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
            confere("pos_rst_fim",     32'(fim),     32'd0);
            confere("pos_rst_ocupado", 32'(ocupado), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
